// File: rtl/iecdrv_gcr_shifter.sv
// GCR bit shifter for a floppy-style drive: serialises write bytes to the head,
// assembles read bytes after sync, and flags byte-ready with overrun detection.
module iecdrv_gcr_shifter #(
  parameter int DW       = 8,
  parameter int SYNC_LEN = 10,
  parameter int BR_LEN   = 4
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          ce,
  input  logic          enable,
  input  logic          mode,
  input  logic          soe,
  input  logic          ack,
  input  logic          hf,
  input  logic [DW-1:0] din,
  output logic          ht,
  output logic [DW-1:0] dout,
  output logic          sync_n,
  output logic          byte_n,
  output logic          ovr
);

  localparam int BW = $clog2(DW);
  localparam int OW = $clog2(SYNC_LEN + 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(DW - 1);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);
  localparam logic [OW-1:0] ONES_MAX = OW'(SYNC_LEN);
  localparam logic [OW-1:0] ONES_ONE = OW'(1);
  localparam logic [7:0]    BR_LOAD  = 8'(BR_LEN);

  logic [BW-1:0] bcnt, bcnt_d;
  logic [OW-1:0] ones, ones_d;
  logic [DW-1:0] rsh, rsh_d;
  logic [DW-1:0] wsh, wsh_d;
  logic [DW-1:0] dout_d;
  logic [7:0]    br_timer;
  logic          ht_d, sync_n_d;
  logic          bnd_d, bnd_q;
  logic          mode_q;
  logic          mode_chg;
  logic          bit_act;

  // A mode change re-frames the stream, so any ce on that edge is discarded.
  assign mode_chg = mode ^ mode_q;
  assign bit_act  = ce & enable & ~mode_chg;

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    bcnt_d = bcnt;
    ones_d = ones;
    rsh_d  = rsh;
    wsh_d  = wsh;
    ht_d   = ht;
    dout_d = dout;
    bnd_d  = 1'b0;
    if (mode_chg) begin
      bcnt_d = '0;
      ones_d = '0;
    end else if (!mode) begin
      ones_d = '0;
      if (bit_act) begin
        if (bcnt == '0) begin
          wsh_d = din;
          ht_d  = din[DW-1];
        end else begin
          wsh_d = {wsh[DW-2:0], 1'b0};
          ht_d  = wsh[DW-2];
        end
        bnd_d  = (bcnt == BCNT_MAX);
        bcnt_d = bnd_d ? '0 : bcnt + BCNT_ONE;
      end
    end else if (bit_act) begin
      rsh_d = {rsh[DW-2:0], hf};
      if (!hf)                  ones_d = '0;
      else if (ones != ONES_MAX) ones_d = ones + ONES_ONE;
      // During sync the frame is pinned; the terminating 0 is already data bit 1.
      if (!sync_n) begin
        bcnt_d = hf ? '0 : BCNT_ONE;
      end else begin
        bnd_d  = (bcnt == BCNT_MAX);
        bcnt_d = bnd_d ? '0 : bcnt + BCNT_ONE;
        if (bnd_d) dout_d = {rsh[DW-2:0], hf};
      end
    end
    sync_n_d = ~(mode && (ones_d == ONES_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      bcnt   <= '0;
      ones   <= '0;
      rsh    <= '0;
      wsh    <= '0;
      ht     <= 1'b0;
      dout   <= '0;
      sync_n <= 1'b1;
      mode_q <= 1'b0;
      bnd_q  <= 1'b0;
    end else begin
      bcnt   <= bcnt_d;
      ones   <= ones_d;
      rsh    <= rsh_d;
      wsh    <= wsh_d;
      ht     <= ht_d;
      dout   <= dout_d;
      sync_n <= sync_n_d;
      mode_q <= mode;
      bnd_q  <= bnd_d & ~mode_chg;
    end
  end

  // Byte-ready handshake: a boundary recorded on one edge is presented on the next.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      byte_n   <= 1'b1;
      br_timer <= '0;
      ovr      <= 1'b0;
    end else begin
      if (mode_chg) begin
        byte_n   <= 1'b1;
        br_timer <= '0;
      end else if (!soe) begin
        byte_n   <= 1'b1;
        br_timer <= '0;
      end else if (bnd_q) begin
        byte_n   <= 1'b0;
        br_timer <= BR_LOAD;
      end else if (ack) begin
        byte_n   <= 1'b1;
        br_timer <= '0;
      end else if (!byte_n) begin
        if (br_timer == 8'd1) begin
          byte_n   <= 1'b1;
          br_timer <= '0;
        end else begin
          br_timer <= br_timer - 8'd1;
        end
      end

      if (!mode_chg) begin
        if (bnd_q && soe && !byte_n && !ack) ovr <= 1'b1;
        else if (ack && !bnd_q)              ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iecdrv_gcr_shifter.sv
// Directed bench for iecdrv_gcr_shifter: byte events are scored through an
// expected-dout queue drained by a monitor; handshake details are checked inline.
module tb_iecdrv_gcr_shifter;

  logic       clk = 1'b0;
  logic       res_n, res2_n;
  logic       ce, enable, mode, soe, ack, ack2, hf;
  logic [7:0] din;
  logic       ht, sync_n, byte_n, ovr;
  logic       ht2, sync_n2, byte_n2, ovr2;
  logic [7:0] dout, dout2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       bn_prev = 1'b1;

  always #5 clk = ~clk;

  iecdrv_gcr_shifter u_dut (
    .clk(clk), .res_n(res_n), .ce(ce), .enable(enable), .mode(mode), .soe(soe),
    .ack(ack), .hf(hf), .din(din), .ht(ht), .dout(dout), .sync_n(sync_n),
    .byte_n(byte_n), .ovr(ovr)
  );

  iecdrv_gcr_shifter #(.BR_LEN(255)) u_dut2 (
    .clk(clk), .res_n(res2_n), .ce(ce), .enable(enable), .mode(mode), .soe(soe),
    .ack(ack2), .hf(hf), .din(din), .ht(ht2), .dout(dout2), .sync_n(sync_n2),
    .byte_n(byte_n2), .ovr(ovr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic b);
    hf = b;
    ce = 1'b1;
    cyc();
    ce = 1'b0;
  endtask

  task automatic read_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      pulse(v[i]);
      if (i != 0) idle(1);
    end
  endtask

  // Monitor: every falling byte_n on the main instance must match the next expected byte.
  always @(negedge clk) begin
    if (res_n && bn_prev && !byte_n) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got dout 0x%0h, want no byte event (t=%0t)", dout, $time);
      end else begin
        check("dout_at_byte", dout, exp_q.pop_front());
      end
    end
    bn_prev <= byte_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int low;
    res_n = 1'b0; res2_n = 1'b0;
    ce = 1'b0; enable = 1'b1; mode = 1'b1; soe = 1'b1;
    ack = 1'b0; ack2 = 1'b0; hf = 1'b0; din = 8'hA5;
    idle(2);
    check("rst_byte_n", byte_n, 1);
    check("rst_sync_n", sync_n, 1);
    check("rst_dout", dout, 0);
    check("rst_ht", ht, 0);
    check("rst_ovr", ovr, 0);
    res_n = 1'b1;
    idle(2);

    // Sync preamble; the 8th one lands on a byte boundary before sync asserts.
    for (int i = 1; i <= 12; i++) begin
      if (i == 8) exp_q.push_back(8'hFF);
      pulse(1'b1);
      if (i == 9)  check("sync_n_9_ones", sync_n, 1);
      if (i == 10) check("sync_n_10_ones", sync_n, 0);
      if (i == 12) check("sync_n_saturated", sync_n, 0);
      idle(5);
    end
    check("bcnt_held_in_sync", u_dut.bcnt, 0);

    pat = 8'h52;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_q.push_back(8'h52);
      pulse(pat[i]);
      if (i == 7) check("sync_n_released", sync_n, 1);
      if (i != 0) idle(1);
    end
    check("byte_n_one_edge_late", byte_n, 1);
    low = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (!byte_n) low++;
    end
    check("byte_n_low_cycles", low, 4);
    check("ovr_single_byte", ovr, 0);

    // Write 0xA5 MSB first.
    mode = 1'b0;
    cyc();
    check("write_sync_n", sync_n, 1);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) exp_q.push_back(8'h52);
      pulse(1'b0);
      check("ht_write", ht, pat[i]);
      if (i == 0) check("write_byte_n_pre", byte_n, 1);
      cyc();
      if (i == 0) check("write_byte_n", byte_n, 0);
      else        check("ht_hold", ht, pat[i]);
    end
    idle(6);

    // Mode toggle mid-byte restarts the frame.
    mode = 1'b1;
    cyc();
    pat = 8'h0D;
    for (int i = 4; i >= 0; i--) begin
      pulse(pat[i]);
      idle(1);
    end
    check("bcnt_before_toggle", u_dut.bcnt, 5);
    mode = 1'b0;
    din  = 8'h5A;
    cyc();
    check("bcnt_after_toggle", u_dut.bcnt, 0);
    check("byte_n_after_toggle", byte_n, 1);
    check("dout_hold_on_toggle", dout, 8'h52);
    pulse(1'b0);
    check("ht_load_after_toggle", ht, 0);
    idle(1);
    pulse(1'b0);
    check("ht_second_after_toggle", ht, 1);

    // Asynchronous reset mid-byte, then restart at bit 0 with gated ce and soe drop.
    #2 res_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_ht", ht, 0);
    check("async_rst_byte_n", byte_n, 1);
    @(negedge clk);
    res_n = 1'b1;
    idle(2);
    din = 8'hC3;
    pat = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          pulse(1'b0);
          idle(1);
        end
        check("ht_hold_disabled", ht, pat[5]);
        check("byte_n_disabled", byte_n, 1);
        enable = 1'b1;
      end
      if (i == 0) exp_q.push_back(8'h00);
      pulse(1'b0);
      check("ht_after_reset", ht, pat[i]);
      if (i != 0) idle(1);
    end
    cyc();
    check("byte_n_after_reset_byte", byte_n, 0);
    soe = 1'b0;
    cyc();
    check("soe_drop_byte_n", byte_n, 1);
    soe = 1'b1;

    // Overrun and ack/boundary collision on the long-timer instance.
    res_n = 1'b0;
    mode  = 1'b1;
    res2_n = 1'b1;
    idle(2);
    read_byte(8'h96);
    cyc();
    check("ovr2_first_byte_n", byte_n2, 0);
    check("ovr2_first_dout", dout2, 8'h96);
    check("ovr2_first_ovr", ovr2, 0);
    read_byte(8'h3C);
    check("ovr2_pre_ovr", ovr2, 0);
    cyc();
    check("ovr2_set", ovr2, 1);
    check("ovr2_byte_n_stays", byte_n2, 0);
    check("ovr2_timer_reload", u_dut2.br_timer, 255);
    check("ovr2_second_dout", dout2, 8'h3C);
    ack2 = 1'b1;
    cyc();
    ack2 = 1'b0;
    check("ack_byte_n", byte_n2, 1);
    check("ack_ovr_clear", ovr2, 0);

    read_byte(8'hF0);
    cyc();
    check("collide_first_byte_n", byte_n2, 0);
    read_byte(8'h0F);
    ack2 = 1'b1;
    cyc();
    ack2 = 1'b0;
    check("collide_byte_n", byte_n2, 0);
    check("collide_timer", u_dut2.br_timer, 255);
    check("collide_ovr", ovr2, 0);
    check("collide_dout", dout2, 8'h0F);

    read_byte(8'h69);
    cyc();
    check("ovr2_again", ovr2, 1);
    pulse(1'b1); idle(1);
    pulse(1'b1); idle(1);
    pulse(1'b0);
    #2 res2_n = 1'b0;
    #1;
    check("async_rst2_byte_n", byte_n2, 1);
    check("async_rst2_ovr", ovr2, 0);
    check("async_rst2_dout", dout2, 0);
    check("async_rst2_sync_n", sync_n2, 1);
    check("async_rst2_ht", ht2, 0);
    idle(2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
